// File: rtl/alu_dispatch_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the execute-stage dispatcher: opcodes, FSM states,
// opcode classes and the response record.
package alu_dispatch_pkg;

   localparam int unsigned DEFAULT_MD_TIMEOUT = 40;

   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SUB  = 5'b00001;
   localparam logic [4:0] OP_AND  = 5'b00010;
   localparam logic [4:0] OP_OR   = 5'b00011;
   localparam logic [4:0] OP_SLL  = 5'b00100;
   localparam logic [4:0] OP_SRA  = 5'b00101;
   localparam logic [4:0] OP_MULT = 5'b00110;
   localparam logic [4:0] OP_DIV  = 5'b00111;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ALU     = 2'd1,
      ST_MD_WAIT = 2'd2,
      ST_RESP    = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      CLS_ALU     = 2'd0,
      CLS_MULT    = 2'd1,
      CLS_DIV     = 2'd2,
      CLS_ILLEGAL = 2'd3
   } op_class_t;

   typedef struct packed {
      logic [31:0] result;
      logic        exception;
   } resp_t;

   function automatic op_class_t decode_class(input logic [4:0] opcode);
      op_class_t cls;
      case (opcode)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLL, OP_SRA: cls = CLS_ALU;
         OP_MULT:                                       cls = CLS_MULT;
         OP_DIV:                                        cls = CLS_DIV;
         default:                                       cls = CLS_ILLEGAL;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/alu_dispatch_timer.sv
`timescale 1ns/1ps
// Clearable saturating cycle counter; expired is high once the count reaches LIMIT.
module dispatch_timer
   import alu_dispatch_pkg::*;
#(
   parameter int unsigned LIMIT = DEFAULT_MD_TIMEOUT
) (
   input  logic clock,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned W = $clog2(LIMIT + 1);
   localparam logic [W-1:0] LIMIT_W = W'(LIMIT);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en && (count_q != LIMIT_W)) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired = (count_q == LIMIT_W);

endmodule

// File: rtl/alu_dispatch.sv
`timescale 1ns/1ps
// Execute-stage issue controller: routes one request to the ALU or mult/div unit,
// collects the result and offers it downstream on a valid/ready handshake.
module alu_dispatch
   import alu_dispatch_pkg::*;
#(
   parameter int unsigned MD_TIMEOUT = DEFAULT_MD_TIMEOUT
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [4:0]  in_opcode,
   input  logic [4:0]  in_shamt,
   input  logic [31:0] in_a,
   input  logic [31:0] in_b,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [4:0]  alu_shamt,
   output logic [2:0]  alu_sel,
   input  logic [31:0] alu_result,
   output logic        md_start,
   output logic        md_is_div,
   output logic [31:0] md_a,
   output logic [31:0] md_b,
   input  logic [31:0] md_result,
   input  logic        md_exception,
   input  logic        md_done,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        out_exception
);

   state_t      state_q, state_d;
   op_class_t   in_class;
   logic        accept;
   logic        timer_expired;

   logic [31:0] alu_a_q, alu_a_d;
   logic [31:0] alu_b_q, alu_b_d;
   logic [4:0]  alu_shamt_q, alu_shamt_d;
   logic [2:0]  alu_sel_q, alu_sel_d;
   logic [31:0] md_a_q, md_a_d;
   logic [31:0] md_b_q, md_b_d;
   logic        md_start_q, md_start_d;
   logic        md_is_div_q, md_is_div_d;
   logic        out_valid_q, out_valid_d;
   resp_t       resp_q, resp_d;

   assign in_class = decode_class(in_opcode);
   assign in_ready = (state_q == ST_IDLE);
   assign accept   = in_valid && in_ready;

   // Counter restarts on every MD_WAIT entry because it is held clear elsewhere.
   dispatch_timer #(
      .LIMIT(MD_TIMEOUT)
   ) u_md_timer (
      .clock  (clock),
      .reset  (reset),
      .clr    (state_q != ST_MD_WAIT),
      .en     (state_q == ST_MD_WAIT),
      .expired(timer_expired)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: each combinational output is defaulted first, so no branch can infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               case (in_class)
                  CLS_ALU:           state_d = ST_ALU;
                  CLS_MULT, CLS_DIV: state_d = ST_MD_WAIT;
                  default:           state_d = ST_RESP;
               endcase
            end
         end
         ST_ALU:     state_d = ST_RESP;
         ST_MD_WAIT: if (md_done || timer_expired) state_d = ST_RESP;
         ST_RESP:    if (out_ready) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_shamt_d = alu_shamt_q;
      alu_sel_d   = alu_sel_q;
      md_a_d      = md_a_q;
      md_b_d      = md_b_q;
      md_is_div_d = md_is_div_q;
      resp_d      = resp_q;
      md_start_d  = 1'b0;
      out_valid_d = (state_d == ST_RESP);
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               alu_a_d     = in_a;
               alu_b_d     = in_b;
               alu_shamt_d = in_shamt;
               alu_sel_d   = in_opcode[2:0];
               md_a_d      = in_a;
               md_b_d      = in_b;
               md_is_div_d = (in_class == CLS_DIV);
               md_start_d  = (in_class == CLS_MULT) || (in_class == CLS_DIV);
               if (in_class == CLS_ILLEGAL) begin
                  resp_d = '{result: 32'd0, exception: 1'b1};
               end
            end
         end
         ST_ALU: begin
            resp_d = '{result: alu_result, exception: 1'b0};
         end
         ST_MD_WAIT: begin
            // A completion coinciding with the timeout still delivers its result.
            if (md_done) begin
               resp_d = '{result: md_result, exception: md_exception};
            end else if (timer_expired) begin
               resp_d = '{result: 32'd0, exception: 1'b1};
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_shamt_q <= '0;
         alu_sel_q   <= '0;
         md_a_q      <= '0;
         md_b_q      <= '0;
         md_start_q  <= 1'b0;
         md_is_div_q <= 1'b0;
         out_valid_q <= 1'b0;
         resp_q      <= '0;
      end else begin
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_shamt_q <= alu_shamt_d;
         alu_sel_q   <= alu_sel_d;
         md_a_q      <= md_a_d;
         md_b_q      <= md_b_d;
         md_start_q  <= md_start_d;
         md_is_div_q <= md_is_div_d;
         out_valid_q <= out_valid_d;
         resp_q      <= resp_d;
      end
   end

   assign alu_a         = alu_a_q;
   assign alu_b         = alu_b_q;
   assign alu_shamt     = alu_shamt_q;
   assign alu_sel       = alu_sel_q;
   assign md_a          = md_a_q;
   assign md_b          = md_b_q;
   assign md_start      = md_start_q;
   assign md_is_div     = md_is_div_q;
   assign out_valid     = out_valid_q;
   assign out_result    = resp_q.result;
   assign out_exception = resp_q.exception;

endmodule
